steer_queue: RTL
================

// Module: steer_queue
// PURPOSE
//  Consumes the PS/2 controller's key LUTs (make_lut, persist_lut) and turns them into game steering for
//  two lightbike players. Edge-captures make events, drives the controller's reset_make strobe and queues
//  turns per player. Releases one turn per game tick so fast key sequences are neither lost nor reversed.
//  Sits between the keyboard controller and the game-step engine.
// PARAMETERS
//  QDEPTH    2  per-player turn queue depth (entries, >=1)
//  CLR_HOLD  1  cycles spent in HOLD after a clear strobe before rescanning (>=1)
// PORTS
//  c50          in   1    50 MHz system clock, all logic on posedge
//  reset_all    in   1    asynchronous, active-low reset
//  make_lut     in   512  sticky make flags from controller, index {E0,code}
//  persist_lut  in   512  held-key flags from controller
//  tick         in   1    one-cycle game-step strobe
//  clr_make     out  1    active-low strobe to controller reset_make
//  p1_dir       out  2    player-1 heading: 0 up, 1 right, 2 down, 3 left
//  p2_dir       out  2    player-2 heading, same encoding
//  p1_boost     out  1    player-1 boost held
//  p2_boost     out  1    player-2 boost held
//  paused       out  1    game paused flag
//  p1_qcnt      out  $clog2(QDEPTH+1)  player-1 queued turns
//  p2_qcnt      out  $clog2(QDEPTH+1)  player-2 queued turns
// BEHAVIOUR
//  Reset (async, reset_all=0): p1_dir=1 (right), p2_dir=3 (left), queues empty, qcnt=0, paused=1,
//   boosts=0, clr_make=1, FSM=SCAN.
//  Key map (LUT index): P1 W=0x01D, D=0x023, S=0x01B, A=0x01C; P2 up=0x175, right=0x174, down=0x172,
//   left=0x16B; pause SPACE=0x029; boost P1 LSHIFT=0x012, P2 RSHIFT=0x059.
//  FSM:
//   - SCAN: if any of the 9 mapped make bits is 1, latch them into a snapshot and go to CLEAR; else stay.
//   - CLEAR: clr_make=0 for exactly one cycle (the controller clears on the negedge inside it), then go to HOLD.
//   - HOLD: clr_make=1 for CLR_HOLD cycles, then SCAN. Snapshot is processed on the CLEAR cycle.
//   - Makes set by the controller after the snapshot edge but before its clear are discarded (accepted loss).
//  Turn push (per player, on CLEAR cycle):
//   - If several direction bits are set, one candidate is chosen by priority up>right>down>left.
//   - ref = tail entry of the queue, or the current dir if the queue is empty after this cycle's pop.
//   - Candidate is dropped if it equals ref or equals ref^2 (reversal).
//   - Candidate is dropped if the queue is full after this cycle's pop.
//   - Otherwise it is appended and qcnt increments.
//  Pause: SPACE bit in snapshot toggles paused on the CLEAR cycle. Turns still queue while paused.
//  Tick: if tick=1 and paused=0, each non-empty queue pops its head into pX_dir the next cycle
//   (1-cycle latency); empty queue leaves dir unchanged. Ticks while paused are ignored.
//  Simultaneous tick+push: pop happens first; full queue with pop accepts push; qcnt reflects both (net 0).
//  Boost: pX_boost = registered persist_lut bit (1-cycle latency) AND ~paused.
//  Reset mid-CLEAR forces clr_make=1 immediately (async) and discards the snapshot.
// TESTING
//  1. Reset, no keys -> dirs 1/3, paused=1, clr_make=1, qcnt=0; SPACE make -> one clr_make low pulse, paused=0.
//  2. paused=0, P1 W make then tick -> p1_qcnt 0->1->0, p1_dir=0 one cycle after tick.
//  3. P1 dir=1: A make (left) -> dropped, qcnt stays 0; S, W, S in separate scans -> W is a reversal of S so
//     dropped, queue holds S then second S dropped (equal) -> qcnt=1.
//  4. QDEPTH=2: push up, left, down with no ticks -> down dropped, qcnt=2; tick coincident with push -> qcnt=2.
//  5. Both P1 W and D set in one snapshot -> only up queued; P2 arrows independent in same snapshot.
//  6. LSHIFT persist=1 while paused -> p1_boost=0; unpause -> 1; reset_all low during CLEAR -> clr_make=1 at once.

Source files
------------

// File: rtl/steer_queue.sv
// Keyboard-to-steering bridge for two lightbike players.
// Edge-captures make flags, strobes the controller clear, queues turns per tick.
module steer_queue #(
  parameter int QDEPTH   = 2,
  parameter int CLR_HOLD = 1
) (
  input  logic                         c50,
  input  logic                         reset_all,
  input  logic [511:0]                 make_lut,
  input  logic [511:0]                 persist_lut,
  input  logic                         tick,
  output logic                         clr_make,
  output logic [1:0]                   p1_dir,
  output logic [1:0]                   p2_dir,
  output logic                         p1_boost,
  output logic                         p2_boost,
  output logic                         paused,
  output logic [$clog2(QDEPTH+1)-1:0]  p1_qcnt,
  output logic [$clog2(QDEPTH+1)-1:0]  p2_qcnt
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int HW = $clog2(CLR_HOLD + 1);

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    CLEAR = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [HW-1:0]   hold_cnt;
  logic [8:0]      keys;
  logic [8:0]      snap;
  logic            do_clear;
  logic            paused_q;
  logic [1:0]      boost_q;
  logic            unused_bits;

  // bit order: space, p2 l/d/r/u, p1 l/d/r/u
  assign keys = {
    make_lut[9'h029],
    make_lut[9'h16B], make_lut[9'h172],
    make_lut[9'h174], make_lut[9'h175],
    make_lut[9'h01C], make_lut[9'h01B],
    make_lut[9'h023], make_lut[9'h01D]
  };

  assign unused_bits = ^{make_lut, persist_lut};

  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      state <= SCAN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      SCAN:  if (|keys) state_n = CLEAR;
      CLEAR: state_n = HOLD;
      HOLD:  if (hold_cnt == HW'(CLR_HOLD - 1)) state_n = SCAN;
      default: state_n = SCAN;
    endcase
  end

  always_comb begin
    clr_make = (state != CLEAR);
    do_clear = (state == CLEAR);
  end

  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      hold_cnt <= '0;
      snap     <= '0;
      paused_q <= 1'b1;
      boost_q  <= '0;
    end else begin
      if (state == CLEAR) begin
        hold_cnt <= '0;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == SCAN && |keys) begin
        snap <= keys;
      end
      if (do_clear && snap[8]) begin
        paused_q <= ~paused_q;
      end
      boost_q <= {persist_lut[9'h059], persist_lut[9'h012]};
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_lane
    localparam logic [1:0] DIR0 = (p == 0) ? 2'd1 : 2'd3;

    logic [3:0]    req;
    logic [1:0]    dir_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_ap;
    logic [1:0]    q_q [QDEPTH];
    logic [1:0]    q_n [QDEPTH];
    logic [1:0]    cand;
    logic [1:0]    tail;
    logic          pop;
    logic          push;

    assign req = snap[4*p +: 4];

    always_comb begin
      pop    = tick & ~paused_q & (cnt_q != '0);
      cnt_ap = cnt_q - CW'(pop);
      cand   = 2'd3;
      if (req[0]) begin
        cand = 2'd0;
      end else if (req[1]) begin
        cand = 2'd1;
      end else if (req[2]) begin
        cand = 2'd2;
      end
      // tail survives a pop unless the queue drains to empty
      tail = dir_q;
      for (int i = 0; i < QDEPTH; i++) begin
        if (cnt_ap != '0 && i == int'(cnt_q) - 1) tail = q_q[i];
      end
      push = do_clear & (|req)
           & (cand != tail)
           & (cand != (tail ^ 2'd2))
           & (int'(cnt_ap) < QDEPTH);
      q_n = q_q;
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) q_n[i] = q_q[i+1];
      end
      if (push) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (i == int'(cnt_ap)) q_n[i] = cand;
        end
      end
    end

    always_ff @(posedge c50 or negedge reset_all) begin
      if (!reset_all) begin
        dir_q <= DIR0;
        cnt_q <= '0;
        for (int i = 0; i < QDEPTH; i++) q_q[i] <= 2'd0;
      end else begin
        if (pop) dir_q <= q_q[0];
        cnt_q <= cnt_ap + CW'(push);
        q_q   <= q_n;
      end
    end
  end

  assign p1_dir   = g_lane[0].dir_q;
  assign p2_dir   = g_lane[1].dir_q;
  assign p1_qcnt  = g_lane[0].cnt_q;
  assign p2_qcnt  = g_lane[1].cnt_q;
  assign paused   = paused_q;
  assign p1_boost = boost_q[0] & ~paused_q;
  assign p2_boost = boost_q[1] & ~paused_q;

endmodule
